// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: camera writes vs. VGA reads, read priority with a bounded write-starvation run.
// Write grant-to-ack is WR_CYCLES; reads are 1 + SRAM latency + 1; requesters are held off until their ack.
module sram_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 16,
  parameter int WR_CYCLES  = 2,
  parameter int MAX_RD_RUN = 4,
  parameter int RD_TIMEOUT = 16
) (
  input  logic              clock_200mhz,
  input  logic              reset,
  input  logic              cam_en,
  input  logic              vga_en,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] sram_address,
  output logic [1:0]        sram_byteenable,
  output logic              sram_read,
  output logic              sram_write,
  output logic [DATA_W-1:0] sram_writedata,
  input  logic [DATA_W-1:0] sram_readdata,
  input  logic              sram_readdatavalid,
  output logic              busy,
  output logic              timeout_err
);

  localparam int WC_W = 4;
  localparam int SC_W = $clog2(MAX_RD_RUN + 1);
  localparam int TO_W = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WR_LAST = WC_W'(WR_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RD_TIMEOUT - 1);
  localparam logic [SC_W-1:0] RUN_MAX = SC_W'(MAX_RD_RUN);

  typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_t;

  state_t            state, state_nxt;
  logic [WC_W-1:0]   wr_cnt, wr_cnt_nxt;
  logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
  logic [SC_W-1:0]   starve_cnt, starve_cnt_nxt;
  logic [ADDR_W-1:0] address_nxt;
  logic [1:0]        byteenable_nxt;
  logic              read_nxt, write_nxt;
  logic [DATA_W-1:0] writedata_nxt, rd_data_nxt;
  logic              wr_ack_nxt, rd_ack_nxt, rd_valid_nxt, timeout_err_nxt;
  logic              r, w;

  assign r    = rd_req & vga_en;
  assign w    = wr_req & cam_en;
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt       = state;
    wr_cnt_nxt      = wr_cnt;
    to_cnt_nxt      = to_cnt;
    starve_cnt_nxt  = starve_cnt;
    address_nxt     = sram_address;
    byteenable_nxt  = sram_byteenable;
    read_nxt        = 1'b0;
    write_nxt       = sram_write;
    writedata_nxt   = sram_writedata;
    rd_data_nxt     = rd_data;
    wr_ack_nxt      = 1'b0;
    rd_ack_nxt      = 1'b0;
    rd_valid_nxt    = 1'b0;
    timeout_err_nxt = timeout_err;

    case (state)
      IDLE: begin
        write_nxt      = 1'b0;
        byteenable_nxt = 2'b00;
        // Reads win unless the pending write has already waited out a full read run.
        if (w && (!r || (starve_cnt >= RUN_MAX))) begin
          state_nxt      = WR;
          write_nxt      = 1'b1;
          byteenable_nxt = 2'b11;
          address_nxt    = wr_addr;
          writedata_nxt  = wr_data;
          wr_cnt_nxt     = '0;
          wr_ack_nxt     = (WR_LAST == '0);
          starve_cnt_nxt = '0;
        end else if (r) begin
          state_nxt      = RD;
          read_nxt       = 1'b1;
          byteenable_nxt = 2'b11;
          address_nxt    = rd_addr;
          if (!w)
            starve_cnt_nxt = '0;
          else if (starve_cnt < RUN_MAX)
            starve_cnt_nxt = starve_cnt + SC_W'(1);
        end
      end

      WR: begin
        if (wr_cnt == WR_LAST) begin
          state_nxt      = IDLE;
          write_nxt      = 1'b0;
          byteenable_nxt = 2'b00;
        end else begin
          wr_cnt_nxt = wr_cnt + WC_W'(1);
          wr_ack_nxt = ((wr_cnt + WC_W'(1)) == WR_LAST);
        end
      end

      RD: begin
        state_nxt      = RD_WAIT;
        byteenable_nxt = 2'b00;
        to_cnt_nxt     = '0;
      end

      RD_WAIT: begin
        if (sram_readdatavalid) begin
          state_nxt    = IDLE;
          rd_data_nxt  = sram_readdata;
          rd_valid_nxt = 1'b1;
          rd_ack_nxt   = 1'b1;
        end else if (to_cnt == TO_LAST) begin
          // Lost return: release the requester and leave a sticky flag behind.
          state_nxt       = IDLE;
          rd_ack_nxt      = 1'b1;
          timeout_err_nxt = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_200mhz) begin
    if (reset) begin
      state           <= IDLE;
      wr_cnt          <= '0;
      to_cnt          <= '0;
      starve_cnt      <= '0;
      sram_address    <= '0;
      sram_byteenable <= 2'b00;
      sram_read       <= 1'b0;
      sram_write      <= 1'b0;
      sram_writedata  <= '0;
      rd_data         <= '0;
      wr_ack          <= 1'b0;
      rd_ack          <= 1'b0;
      rd_valid        <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      state           <= state_nxt;
      wr_cnt          <= wr_cnt_nxt;
      to_cnt          <= to_cnt_nxt;
      starve_cnt      <= starve_cnt_nxt;
      sram_address    <= address_nxt;
      sram_byteenable <= byteenable_nxt;
      sram_read       <= read_nxt;
      sram_write      <= write_nxt;
      sram_writedata  <= writedata_nxt;
      rd_data         <= rd_data_nxt;
      wr_ack          <= wr_ack_nxt;
      rd_ack          <= rd_ack_nxt;
      rd_valid        <= rd_valid_nxt;
      timeout_err     <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table of single transactions, scoreboarded SRAM accesses and read data,
// plus hand sequences for reset, starvation, enables, stray returns and reset mid-write.
module tb_sram_arbiter;
  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 16;
  localparam int WR_CYCLES  = 2;
  localparam int MAX_RD_RUN = 4;
  localparam int RD_TIMEOUT = 16;

  logic              clock_200mhz = 1'b0;
  logic              reset = 1'b1;
  logic              cam_en = 1'b0, vga_en = 1'b0;
  logic              wr_req = 1'b0, rd_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ack, rd_ack, rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] sram_address;
  logic [1:0]        sram_byteenable;
  logic              sram_read, sram_write;
  logic [DATA_W-1:0] sram_writedata;
  logic [DATA_W-1:0] sram_readdata = '0;
  logic              sram_readdatavalid = 1'b0;
  logic              busy, timeout_err;

  sram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_CYCLES(WR_CYCLES),
    .MAX_RD_RUN(MAX_RD_RUN), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clock_200mhz(clock_200mhz), .reset(reset),
    .cam_en(cam_en), .vga_en(vga_en),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .sram_address(sram_address), .sram_byteenable(sram_byteenable),
    .sram_read(sram_read), .sram_write(sram_write), .sram_writedata(sram_writedata),
    .sram_readdata(sram_readdata), .sram_readdatavalid(sram_readdatavalid),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial forever #5 clock_200mhz = ~clock_200mhz;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit                is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } acc_t;

  typedef struct {
    bit                is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                lat;       // SRAM return latency in cycles; 0 = never returns
    bit                exp_terr;
  } vec_t;

  acc_t              exp_acc[$];
  logic [DATA_W-1:0] exp_rd[$];

  // SRAM controller model: answers a read strobe sram_lat cycles later.
  int                sram_lat = 3;
  int                rv_cnt = -1;
  bit                stray = 1'b0;
  logic [DATA_W-1:0] ret_data = '0;

  initial forever begin
    @(posedge clock_200mhz);
    #1;
    sram_readdatavalid = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        sram_readdata      = ret_data;
        sram_readdatavalid = 1'b1;
        rv_cnt             = -1;
      end
    end
    if (stray) begin
      sram_readdata      = 16'hBEEF;
      sram_readdatavalid = 1'b1;
      stray              = 1'b0;
    end
    if (sram_read) rv_cnt = (sram_lat > 0) ? sram_lat : -1;
  end

  // Monitor: pops the expected access on each new strobe and the expected data on each rd_valid.
  int n_starts = 0;
  int n_wack   = 0;
  int n_rdv    = 0;
  int wr_run   = 0;
  bit prev_wr  = 1'b0;

  initial begin : monitor
    acc_t e;
    forever begin
      @(negedge clock_200mhz);
      if ((sram_write && !prev_wr) || sram_read) begin
        n_starts++;
        if (exp_acc.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: got %s at addr %0h, expected no access",
                   sram_write ? "write" : "read", sram_address);
        end else begin
          e = exp_acc.pop_front();
          check("acc_kind_is_write", {63'd0, sram_write}, {63'd0, e.is_wr});
          check("acc_addr", 64'(sram_address), 64'(e.addr));
          check("acc_byteenable", 64'(sram_byteenable), 64'd3);
          if (e.is_wr) check("acc_writedata", 64'(sram_writedata), 64'(e.data));
        end
      end
      if (!sram_write && prev_wr && !reset) check("wr_strobe_len", 64'(wr_run), 64'(WR_CYCLES));
      wr_run = sram_write ? wr_run + 1 : 0;
      if (wr_ack) begin
        n_wack++;
        check("wr_ack_cycle", 64'(wr_run), 64'(WR_CYCLES));
      end
      if (rd_valid) begin
        n_rdv++;
        check("rd_ack_with_valid", {63'd0, rd_ack}, 64'd1);
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rd_valid: got data %0h, expected no rd_valid", rd_data);
        end else begin
          check("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
        end
      end
      prev_wr = sram_write;
    end
  end

  task automatic do_txn(input vec_t v, input int idx);
    int t_st, t_ack;
    bit done;
    @(negedge clock_200mhz);
    exp_acc.push_back('{v.is_wr, v.addr, v.data});
    if (v.is_wr) begin
      wr_addr = v.addr;
      wr_data = v.data;
      wr_req  = 1'b1;
    end else begin
      rd_addr  = v.addr;
      sram_lat = v.lat;
      ret_data = v.data;
      rd_req   = 1'b1;
      if (v.lat > 0) exp_rd.push_back(v.data);
    end
    t_st = -1;
    t_ack = -1;
    done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clock_200mhz);
      if (t_st < 0 && (sram_read || sram_write)) t_st = k;
      if (v.is_wr ? wr_ack : rd_ack) begin
        t_ack = k;
        done  = 1'b1;
      end
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    check($sformatf("v%0d_ack_seen", idx), {63'd0, done}, 64'd1);
    if (v.is_wr) begin
      check($sformatf("v%0d_wr_ack_offset", idx), 64'(t_ack - t_st), 64'(WR_CYCLES - 1));
    end else begin
      check($sformatf("v%0d_rd_ack_offset", idx), 64'(t_ack - t_st),
            64'((v.lat > 0) ? v.lat + 1 : RD_TIMEOUT + 1));
      check($sformatf("v%0d_rd_valid_at_ack", idx), {63'd0, rd_valid}, 64'(v.lat > 0));
      check($sformatf("v%0d_timeout_err", idx), {63'd0, timeout_err}, 64'(v.exp_terr));
    end
    @(negedge clock_200mhz);
    check($sformatf("v%0d_busy_after", idx), {63'd0, busy}, 64'd0);
  endtask

  task automatic run_until(input int n_wr, input int n_rd, input string name);
    int cw = 0;
    int cr = 0;
    for (int k = 0; k < 400 && (cw < n_wr || cr < n_rd); k++) begin
      @(negedge clock_200mhz);
      if (wr_ack) cw++;
      if (rd_ack) cr++;
      if (cw >= n_wr) wr_req = 1'b0;
      if (cr >= n_rd) rd_req = 1'b0;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    check({name, "_wr_acks"}, 64'(cw), 64'(n_wr));
    check({name, "_rd_acks"}, 64'(cr), 64'(n_rd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  vec_t vecs[8];
  int   base;
  bit   seen;

  initial begin
    vecs[0] = '{1'b1, 19'h12345, 16'hF81F, 0, 1'b0};
    vecs[1] = '{1'b0, 19'h00010, 16'h07E0, 3, 1'b0};
    vecs[2] = '{1'b0, 19'h7FFFF, 16'hFFFF, 1, 1'b0};
    vecs[3] = '{1'b1, 19'h00000, 16'h0000, 0, 1'b0};
    vecs[4] = '{1'b0, 19'h2AAAA, 16'h1234, 6, 1'b0};
    vecs[5] = '{1'b0, 19'h00011, 16'h0000, 0, 1'b1};
    vecs[6] = '{1'b0, 19'h00012, 16'hABCD, 2, 1'b1};
    vecs[7] = '{1'b1, 19'h7FFFF, 16'h07E0, 0, 1'b0};

    // Reset with both requests pending: outputs quiet, then the read wins first.
    cam_en = 1'b1; vga_en = 1'b1;
    wr_addr = 19'h00AAA; wr_data = 16'h5555; wr_req = 1'b1;
    rd_addr = 19'h00100; ret_data = 16'h0F0F; sram_lat = 3; rd_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock_200mhz);
      check($sformatf("reset_outputs_c%0d", c),
            64'({wr_ack, rd_ack, rd_valid, sram_read, sram_write, sram_byteenable, busy,
                 timeout_err, rd_data, sram_address, sram_writedata}), 64'd0);
    end
    exp_acc.push_back('{1'b0, 19'h00100, 16'h0000});
    exp_acc.push_back('{1'b1, 19'h00AAA, 16'h5555});
    exp_rd.push_back(16'h0F0F);
    reset = 1'b0;
    run_until(1, 1, "post_reset");

    for (int i = 0; i < 8; i++) do_txn(vecs[i], i);

    // Both requests held: reads come in runs of MAX_RD_RUN, then a forced write.
    @(negedge clock_200mhz);
    wr_addr = 19'h0BEEF; wr_data = 16'hCAFE;
    rd_addr = 19'h00200; ret_data = 16'h1357; sram_lat = 2;
    for (int g = 0; g < 10; g++) begin
      if ((g % (MAX_RD_RUN + 1)) == MAX_RD_RUN) exp_acc.push_back('{1'b1, 19'h0BEEF, 16'hCAFE});
      else begin
        exp_acc.push_back('{1'b0, 19'h00200, 16'h0000});
        exp_rd.push_back(16'h1357);
      end
    end
    wr_req = 1'b1; rd_req = 1'b1;
    run_until(2, 8, "starve");

    // Disabled ports ignore their requests.
    @(negedge clock_200mhz);
    base = n_starts;
    cam_en = 1'b0; wr_req = 1'b1;
    repeat (20) @(negedge clock_200mhz);
    check("cam_en_off_no_access", 64'(n_starts - base), 64'd0);
    wr_req = 1'b0; cam_en = 1'b1;
    vga_en = 1'b0; rd_req = 1'b1;
    repeat (20) @(negedge clock_200mhz);
    check("vga_en_off_no_access", 64'(n_starts - base), 64'd0);
    check("vga_en_off_busy", {63'd0, busy}, 64'd0);
    rd_req = 1'b0; vga_en = 1'b1;

    // A read return while idle must be dropped.
    base = n_rdv;
    stray = 1'b1;
    repeat (4) @(negedge clock_200mhz);
    check("stray_valid_ignored", 64'(n_rdv - base), 64'd0);
    check("rd_data_held", 64'(rd_data), 64'h1357);
    check("timeout_err_sticky", {63'd0, timeout_err}, 64'd1);

    // Reset in the first write cycle aborts without an ack.
    @(negedge clock_200mhz);
    exp_acc.push_back('{1'b1, 19'h01234, 16'h4321});
    wr_addr = 19'h01234; wr_data = 16'h4321; wr_req = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clock_200mhz);
      if (sram_write) seen = 1'b1;
    end
    check("abort_write_started", {63'd0, seen}, 64'd1);
    base = n_wack;
    reset = 1'b1; wr_req = 1'b0;
    @(negedge clock_200mhz);
    check("abort_write_dropped", {63'd0, sram_write}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    @(negedge clock_200mhz);
    reset = 1'b0;
    repeat (3) @(negedge clock_200mhz);
    check("abort_no_wr_ack", 64'(n_wack - base), 64'd0);
    check("timeout_err_cleared", {63'd0, timeout_err}, 64'd0);

    do_txn(vecs[0], 8);

    repeat (3) @(negedge clock_200mhz);
    check("acc_queue_drained", 64'(exp_acc.size()), 64'd0);
    check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Single-port arbiter between the camera pixel writer and the VGA pixel reader for the external SRAM controller (Avalon-style slave).
- Runs in the 200 MHz domain.
- Serialises requests and enforces read priority for display, with a bounded-starvation guarantee for camera writes.
- Tracks one outstanding read and flags lost read returns with a sticky timeout error.

Parameters:
- ADDR_W, 19, SRAM word address width.
- DATA_W, 16, pixel word width (RGB565).
- WR_CYCLES, 2, cycles sram_write is held per write (1..15).
- MAX_RD_RUN, 4, max consecutive read grants while a write is pending before a write is forced.
- RD_TIMEOUT, 16, cycles to wait for sram_readdatavalid before abandoning a read.

Ports:
- clock_200mhz  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cam_en  in  1  enables write port; when 0, wr_req is ignored
- vga_en  in  1  enables read port; when 0, rd_req is ignored
- wr_req  in  1  camera write request, held until wr_ack
- wr_addr  in  ADDR_W  write address, stable while wr_req
- wr_data  in  DATA_W  write data, stable while wr_req
- wr_ack  out  1  one-cycle pulse, write completed
- rd_req  in  1  VGA read request, held until rd_ack
- rd_addr  in  ADDR_W  read address, stable while rd_req
- rd_ack  out  1  one-cycle pulse, read finished (data or timeout)
- rd_data  out  DATA_W  read data, valid with rd_valid, held until next rd_valid
- rd_valid  out  1  one-cycle pulse, rd_data updated
- sram_address  out  ADDR_W  to SRAM controller
- sram_byteenable  out  2  2'b11 during access, else 2'b00
- sram_read  out  1  read strobe
- sram_write  out  1  write strobe
- sram_writedata  out  DATA_W  write data
- sram_readdata  in  DATA_W  read return data
- sram_readdatavalid  in  1  read return qualifier
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky, set on read timeout, cleared only by reset

Behaviour:

Reset:
- All outputs 0; rd_data 0; FSM in IDLE; starve_cnt 0; timeout counter 0.
- Reset mid-access aborts immediately: strobes drop on the next edge and no ack is issued.

FSM states: IDLE, WR, RD, RD_WAIT.

IDLE:
- Samples r = rd_req & vga_en and w = wr_req & cam_en.
- r & w: choose WR if starve_cnt >= MAX_RD_RUN, else RD.
- Only r: RD. Only w: WR. Neither: stay in IDLE.
- Address, byteenable, writedata and strobes are registered on the transition edge.

WR:
- sram_write=1, sram_byteenable=2'b11, sram_address=wr_addr, sram_writedata=wr_data for exactly WR_CYCLES cycles.
- wr_ack pulses in the last of these cycles.
- Next state IDLE; all strobes and byteenable are 0 in IDLE.
- starve_cnt clears to 0 on WR grant.

RD:
- sram_read=1, byteenable 2'b11, sram_address=rd_addr for 1 cycle, then go to RD_WAIT.
- On RD grant, starve_cnt increments (saturating at MAX_RD_RUN) only if w is also high; otherwise it clears.

RD_WAIT:
- sram_read=0; counter runs from 0.
- On sram_readdatavalid: rd_data <= sram_readdata; rd_valid and rd_ack pulse next cycle; return to IDLE.
- If the counter reaches RD_TIMEOUT-1 without readdatavalid: rd_ack pulses with no rd_valid, timeout_err set, return to IDLE.
- sram_readdatavalid arriving outside RD_WAIT is ignored.

Throughput and latency:
- Minimum turnaround 1 IDLE cycle between accesses.
- Write grant-to-ack latency is WR_CYCLES.
- Read latency = 1 + SRAM return latency + 1.

Request rules:
- A request deasserted before its ack is a protocol violation; behaviour is undefined except that the FSM must still return to IDLE.
- An enable dropping mid-access does not abort the access in flight.
- Addresses are not checked; wrap is the SRAM controller's concern.

Test Plan:
- Reset check: reset=1 for 3 cycles with wr_req=rd_req=1 -> all outputs 0, no strobes; after release with cam_en=vga_en=1 -> the first grant is RD.
- Single write: wr_addr=19'h12345, wr_data=16'hF81F -> sram_write high exactly 2 cycles with those values and byteenable 2'b11; wr_ack pulses in the 2nd cycle; busy drops the next cycle.
- Single read: rd_addr=19'h00010, SRAM model returns 16'h07E0 with readdatavalid 3 cycles after sram_read -> rd_data=16'h07E0; rd_valid and rd_ack pulse together; timeout_err stays 0.
- Starvation bound: rd_req and wr_req held high continuously -> grant sequence R,R,R,R,W repeating; wr_ack every 5th access.
- Read timeout: SRAM model never returns data -> rd_ack pulses 16 cycles into RD_WAIT, rd_valid stays 0, timeout_err=1 and stays 1 through later successful reads until reset.
- Enables and reset mid-access:
  - cam_en=0 with wr_req=1 -> no write is ever issued.
  - Reset asserted in the 1st WR cycle -> sram_write=0 next edge; no wr_ack.
